keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Scans a 4x4 matrix keypad and emits one debounced key code per press.
//  Sits directly upstream of the adder/display top: its key_code/key_valid
//  pair is the digit-entry source that feeds the operand registers.
//  The downstream top then drives the 7-segment anodes/segments.
// PARAMETERS
//  SCAN_DIV        1000  clk cycles each row stays driven while scanning (>=4)
//  DEBOUNCE_CYCLES 20000 consecutive stable cycles for press/release (>=2)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  col        in   4  keypad columns, active-high; col[3]=leftmost column
//  fil        out  4  keypad rows, one-hot active-high; fil[0]=top row
//  key_code   out  4  code of last accepted key
//  key_valid  out  1  one-cycle pulse when key_code is updated
//  key_held   out  1  high from key_valid until release is debounced
// BEHAVIOUR
//  Reset
//   - One clock; rst asynchronous, active-high.
//   - Reset values: fil=4'b0001, key_code=4'h0, key_valid=0, key_held=0.
//   - Reset also clears: state=SCAN, all counters=0, col synchronizer=0.
//   - rst mid-debounce or mid-hold aborts; no key_valid is produced.
//  Input path
//   - col passes through a 2-FF synchronizer (col_s) before any use.
//  Key map [row][col0..col3]
//   - Row 0: 1 2 3 A.  Row 1: 4 5 6 B.  Row 2: 7 8 9 C.  Row 3: * 0 # D.
//   - Codes: digits=value, A-D=4'hA-4'hD, '*'=4'hE, '#'=4'hF.
//  FSM SCAN
//   - fil rotates 0001->0010->0100->1000->0001, every SCAN_DIV cycles.
//   - col_s one-hot: latch row index + col_s, freeze fil, go DEBOUNCE.
//   - col_s == 0: keep scanning.
//   - col_s with 2+ bits set: ignored, keep scanning.
//   - Sampling is blocked for the first 2 cycles after each row change
//     (synchronizer settle time).
//  FSM DEBOUNCE
//   - Count cycles while col_s == latched col.
//   - Any mismatch: counter=0, return to SCAN; rotation resumes from frozen row.
//   - Count reaches DEBOUNCE_CYCLES:
//       next cycle key_code=decoded value, key_valid=1 for 1 cycle,
//       key_held=1, go HELD.
//  FSM HELD
//   - fil stays frozen. No auto-repeat.
//   - Other keys pressed meanwhile are ignored.
//   - Count consecutive cycles with col_s == 0; any nonzero col_s resets count.
//   - Count reaches DEBOUNCE_CYCLES: key_held=0, go SCAN; row advances.
//  Latency and persistence
//   - Stable press on the driven row -> key_valid:
//       2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//   - key_code holds its value until the next accepted press.
//  Counters
//   - Counters saturate; they never wrap.
//   - Width = $clog2(param+1).
// TESTING (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
//  1 Reset:
//    rst pulse -> fil=0001, key_code=0, key_valid=0, key_held=0,
//    asynchronously, before any clk edge.
//  2 Clean press:
//    col=4'b1000 while fil=0001, held 30 cycles -> one key_valid pulse,
//    key_code=4'h1, at 11 cycles after press.
//  3 Row 3 press:
//    col=4'b0100 while fil=1000 -> key_code=4'h0;
//    col=4'b0001 on the same row -> key_code=4'hD.
//  4 Bounce:
//    col toggles 1000/0000 every 3 cycles for 20 cycles, then stable ->
//    exactly one key_valid, none during bounce.
//  5 Hold/release:
//    hold col=0010 on row 1 for 100 cycles -> single pulse (4'h6);
//    key_held drops 8+2 cycles after release.
//  6 Abort/invalid:
//    rst during DEBOUNCE -> no pulse;
//    col=4'b1100 -> no pulse, fil keeps rotating.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner. Drives one row at a time, watches
// the synchronized columns, debounces a single pressed key and then waits for
// a debounced release before scanning again. One key_valid pulse per press.
module keypad_scan #(
    parameter int SCAN_DIV        = 1000,   // cycles each row stays driven (>= 4)
    parameter int DEBOUNCE_CYCLES = 20000   // stable cycles for press/release (>= 2)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] fil,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    // Last cycle of a row's dwell, and first cycle the synchronizer has
    // caught up with the newly driven row.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] SETTLE   = DIV_W'(2);

    // Entering DEBOUNCE already counts the first stable cycle, so a press is
    // accepted one cycle after the count reaches DEBOUNCE_CYCLES. The release
    // count starts from zero in HELD and finishes on the cycle it would reach
    // DEBOUNCE_CYCLES.
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] REL_DONE = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       col_meta;
    logic [3:0]       col_s;
    logic [3:0]       col_lat;
    logic [1:0]       state;
    logic [1:0]       row;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic             col_onehot;
    logic             sample_ok;
    logic [1:0]       col_idx;
    logic [3:0]       dec_code;

    // Two-flop synchronizer for the asynchronous keypad columns.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers are written with <= so every flop samples the
        // pre-edge value; blocking here would collapse the two stages into one.
        if (rst) begin
            col_meta <= 4'b0000;
            col_s    <= 4'b0000;
        end else begin
            col_meta <= col;
            col_s    <= col_meta;
        end
    end

    assign col_onehot = (col_s != 4'b0000) && ((col_s & (col_s - 4'd1)) == 4'b0000);
    assign sample_ok  = (div_cnt >= SETTLE);
    assign fil        = 4'b0001 << row;

    // Latched column to key-map column index; col[3] is the leftmost column.
    always_comb begin
        // NOTE: the default assignment up front keeps this purely
        // combinational; a path that skipped the assignment would infer a latch.
        col_idx = 2'd0;
        case (col_lat)
            4'b0100: col_idx = 2'd1;
            4'b0010: col_idx = 2'd2;
            4'b0001: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Key map: row-major, leftmost column first; '*' = E, '#' = F.
    always_comb begin
        dec_code = 4'h0;
        case ({row, col_idx})
            4'h0: dec_code = 4'h1;
            4'h1: dec_code = 4'h2;
            4'h2: dec_code = 4'h3;
            4'h3: dec_code = 4'hA;
            4'h4: dec_code = 4'h4;
            4'h5: dec_code = 4'h5;
            4'h6: dec_code = 4'h6;
            4'h7: dec_code = 4'hB;
            4'h8: dec_code = 4'h7;
            4'h9: dec_code = 4'h8;
            4'hA: dec_code = 4'h9;
            4'hB: dec_code = 4'hC;
            4'hC: dec_code = 4'hE;
            4'hD: dec_code = 4'h0;
            4'hE: dec_code = 4'hF;
            4'hF: dec_code = 4'hD;
            default: dec_code = 4'h0;
        endcase
    end

    // Scan / debounce / held state machine with its counters and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SCAN;
            row       <= 2'd0;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            col_lat   <= 4'b0000;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (sample_ok && col_onehot) begin
                        // Freeze the row and start counting stable cycles.
                        col_lat <= col_s;
                        deb_cnt <= DEB_ONE;
                        div_cnt <= '0;
                        state   <= ST_DEBOUNCE;
                    end else if (div_cnt >= DIV_LAST) begin
                        row     <= row + 2'd1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s != col_lat) begin
                        // Bounce or a second key: resume scanning this row
                        // with a fresh dwell, including its settle window.
                        deb_cnt <= '0;
                        state   <= ST_SCAN;
                    end else if (deb_cnt >= DEB_DONE) begin
                        key_code  <= dec_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        deb_cnt   <= '0;
                        state     <= ST_HELD;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                ST_HELD: begin
                    if (col_s != 4'b0000) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt >= REL_DONE) begin
                        key_held <= 1'b0;
                        deb_cnt  <= '0;
                        row      <= row + 2'd1;
                        div_cnt  <= '0;
                        state    <= ST_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: begin
                    deb_cnt <= '0;
                    div_cnt <= '0;
                    state   <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed and randomized stimulus for keypad_scan with a
// behavioural keypad and a cycle-level reference model of the scanner.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] fil;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .fil       (fil),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Physical keypad: the pressed key's column bit shows up only while its row is driven.
    int         press_row;
    logic [3:0] press_mask;
    bit         press_on;

    // Reference model state.
    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_HELD = 2;
    int         m_mode, m_row, m_dwell, m_run;
    logic [3:0] m_lat, m_code;
    bit         m_valid, m_held;
    logic [3:0] hist[$];
    logic [3:0] keymap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                  '{4'h4, 4'h5, 4'h6, 4'hB},
                                  '{4'h7, 4'h8, 4'h9, 4'hC},
                                  '{4'hE, 4'h0, 4'hF, 4'hD}};

    int         pulses;
    int         fil_changes;
    logic [3:0] last_fil;
    int         first;
    int         reached;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int leftmost_idx(input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[3-i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode  = M_SCAN;
        m_row   = 0;
        m_dwell = 0;
        m_run   = 0;
        m_lat   = 4'h0;
        m_code  = 4'h0;
        m_valid = 0;
        m_held  = 0;
        hist    = {4'h0, 4'h0};
    endtask

    // One clock edge of the model; c_now is the column value applied before this edge.
    task automatic model_edge(input logic [3:0] c_now);
        logic [3:0] s;
        s = hist[1];                 // what the scanner sees: columns from two edges ago
        hist.push_front(c_now);
        hist.delete(2);
        m_valid = 0;
        case (m_mode)
            M_SCAN: begin
                if (m_dwell >= 2 && $countones(s) == 1) begin
                    m_mode = M_DEB; m_lat = s; m_run = 1; m_dwell = 0;
                end else if (m_dwell == SCAN_DIV - 1) begin
                    m_row = (m_row + 1) % 4; m_dwell = 0;
                end else begin
                    m_dwell++;
                end
            end
            M_DEB: begin
                if (s != m_lat) begin
                    m_mode = M_SCAN; m_run = 0;
                end else if (m_run == DEB) begin
                    m_code  = keymap[m_row][leftmost_idx(m_lat)];
                    m_valid = 1; m_held = 1; m_mode = M_HELD; m_run = 0;
                end else begin
                    m_run++;
                end
            end
            default: begin
                if (s != 4'h0) begin
                    m_run = 0;
                end else if (m_run + 1 == DEB) begin
                    m_held = 0; m_mode = M_SCAN; m_row = (m_row + 1) % 4;
                    m_dwell = 0; m_run = 0;
                end else begin
                    m_run++;
                end
            end
        endcase
    endtask

    // Drive columns, advance one clock, compare every output against the model.
    task automatic step();
        logic [3:0] f;
        f   = 4'b0001 << m_row;
        col = (press_on && f[press_row]) ? press_mask : 4'b0000;
        @(posedge clk);
        model_edge(col);
        #1;
        f = 4'b0001 << m_row;
        check("fil", fil, f);
        check("key_code", key_code, m_code);
        check("key_valid", {3'b000, key_valid}, {3'b000, m_valid});
        check("key_held", {3'b000, key_held}, {3'b000, m_held});
        if (key_valid) pulses++;
        if (fil !== last_fil) fil_changes++;
        last_fil = fil;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check("rst_fil", fil, 4'b0001);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", {3'b000, key_valid}, 4'h0);
        check("rst_key_held", {3'b000, key_held}, 4'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        last_fil = fil;
    endtask

    initial begin
        rst        = 1'b0;
        col        = 4'b0000;
        press_on   = 0;
        press_row  = 0;
        press_mask = 4'b0000;
        #1;

        // 1 + 2: reset, then a clean press of '1' right as row 0 is driven.
        do_reset();
        press_row = 0; press_mask = 4'b1000; press_on = 1;
        pulses = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (key_valid && first < 0) first = i;
        end
        check_int("t2_latency", first, 11);
        check_int("t2_pulses", pulses, 1);
        check("t2_code", key_code, 4'h1);
        press_on = 0; first = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (!key_held && first < 0) first = i;
        end
        check_int("t2_release", first, 10);

        // 5: long hold of '6' on row 1, single pulse, release timing.
        press_row = 1; press_mask = 4'b0010; press_on = 1; pulses = 0;
        run(100);
        check_int("t5_pulses", pulses, 1);
        check("t5_code", key_code, 4'h6);
        check("t5_held", {3'b000, key_held}, 4'h1);
        press_on = 0; first = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (!key_held && first < 0) first = i;
        end
        check_int("t5_release", first, 10);

        // 3: row 3 keys '0' and 'D'.
        press_row = 3; press_mask = 4'b0100; press_on = 1; pulses = 0;
        run(60);
        check_int("t3_pulses_0", pulses, 1);
        check("t3_code_0", key_code, 4'h0);
        press_on = 0; run(20);
        press_mask = 4'b0001; press_on = 1; pulses = 0;
        run(60);
        check_int("t3_pulses_d", pulses, 1);
        check("t3_code_d", key_code, 4'hD);
        press_on = 0; run(20);

        // 4: bouncing contact, then stable.
        press_row = 0; press_mask = 4'b1000; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            press_on = ((i / 3) % 2) == 0;
            step();
        end
        check_int("t4_bounce_quiet", pulses, 0);
        press_on = 1;
        run(40);
        check_int("t4_pulses", pulses, 1);
        check("t4_code", key_code, 4'h1);
        press_on = 0; run(20);

        // 6a: reset in the middle of a debounce.
        press_row = 0; press_mask = 4'b0010; press_on = 1; reached = 0;
        for (int i = 0; i < 40 && reached == 0; i++) begin
            step();
            if (m_mode == M_DEB && m_run >= 3) reached = 1;
        end
        check_int("t6_reach_debounce", reached, 1);
        do_reset();
        press_on = 0; pulses = 0;
        run(20);
        check_int("t6_abort_pulses", pulses, 0);
        check("t6_abort_code", key_code, 4'h0);

        // 6b: two columns at once are ignored and rotation continues.
        press_row = 0; press_mask = 4'b1100; press_on = 1;
        pulses = 0; fil_changes = 0; last_fil = fil;
        run(40);
        check_int("t6_multi_pulses", pulses, 0);
        check_int("t6_rotations", fil_changes, 10);
        press_on = 0; run(10);

        // 7: random keys, hold and release lengths, occasional double keys.
        for (int k = 0; k < 12; k++) begin
            int bitpos;
            press_row  = $urandom_range(0, 3);
            bitpos     = $urandom_range(0, 3);
            press_mask = 4'b0001 << bitpos;
            if ($urandom_range(0, 4) == 0) press_mask = press_mask | (4'b0001 << ((bitpos + 1) % 4));
            press_on = 1;
            run($urandom_range(0, 40));
            press_on = 0;
            run($urandom_range(0, 30));
        end
        run(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
